// File: rtl/jtag_bus_sram_slave.sv
// jtag_bus_sram_slave: single-port SRAM slave on the shared system bus servicing burst reads and writes
module jtag_bus_sram_slave #(
   parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
   parameter int          ADDR_BITS    = 10
) (
   input  logic        clock,
   input  logic        n_reset,
   input  logic [31:0] address_dataIN,
   input  logic [3:0]  byte_enableIN,
   input  logic [7:0]  burst_sizeIN,
   input  logic        read_n_writeIN,
   input  logic        begin_transactionIN,
   input  logic        end_transactionIN,
   input  logic        data_validIN,
   input  logic        busyIN,
   output logic [31:0] address_dataOUT,
   output logic        end_transactionOUT,
   output logic        data_validOUT,
   output logic        busyOUT,
   output logic        errorOUT
);
   localparam int DEPTH = 1 << ADDR_BITS;
   typedef enum logic [2:0] {IDLE, WSETUP, WRITE, RFETCH, READ, REND, ERROR} state_t;
   state_t               state, state_nxt;
   logic [ADDR_BITS-1:0] index, index_nxt, rd_index;
   logic [8:0]           beats_left, beats_nxt;
   logic [3:0]           byte_en, byte_en_nxt;
   logic                 err_read, err_read_nxt, absorb, absorb_nxt;
   logic                 selected, aligned, consume, wr_en;
   logic [31:0]          mem [DEPTH];
   logic [31:0]          rdata;
   assign selected = address_dataIN[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2];
   assign aligned  = address_dataIN[1:0] == 2'b00;
   assign consume  = state == READ && !busyIN;
   assign wr_en    = state == WRITE && data_validIN && beats_left != 9'd0;
   assign rd_index = consume ? index + 1'b1 : index;
   // transaction state, word index and beat counter; async reset abandons any burst in flight
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state      <= IDLE;
         index      <= '0;
         beats_left <= '0;
         byte_en    <= '0;
         err_read   <= 1'b0;
         absorb     <= 1'b0;
      end else begin
         state      <= state_nxt;
         index      <= index_nxt;
         beats_left <= beats_nxt;
         byte_en    <= byte_en_nxt;
         err_read   <= err_read_nxt;
         absorb     <= absorb_nxt;
      end
   end
   // next-state logic: decode on begin, count beats, abort on master end
   always_comb begin
      state_nxt    = state;
      index_nxt    = index;
      beats_nxt    = beats_left;
      byte_en_nxt  = byte_en;
      err_read_nxt = err_read;
      absorb_nxt   = absorb;
      case (state)
         IDLE: if (begin_transactionIN && selected) begin
            index_nxt    = address_dataIN[ADDR_BITS+1:2];
            beats_nxt    = {1'b0, burst_sizeIN} + 9'd1;
            byte_en_nxt  = byte_enableIN;
            err_read_nxt = read_n_writeIN;
            absorb_nxt   = 1'b0;
            state_nxt    = !aligned ? ERROR : read_n_writeIN ? RFETCH : WSETUP;
         end
         WSETUP: state_nxt = WRITE;
         WRITE: begin
            if (wr_en) begin
               index_nxt = index + 1'b1;
               beats_nxt = beats_left - 9'd1;
            end
            if (end_transactionIN) state_nxt = IDLE;
         end
         RFETCH: state_nxt = end_transactionIN ? IDLE : READ;
         READ: begin
            if (end_transactionIN) state_nxt = IDLE;
            else if (consume) begin
               index_nxt = index + 1'b1;
               beats_nxt = beats_left - 9'd1;
               state_nxt = beats_left == 9'd1 ? REND : READ;
            end
         end
         REND: state_nxt = IDLE;
         ERROR: begin
            absorb_nxt = 1'b1;
            if (err_read || end_transactionIN) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // SRAM array: byte-lane writes and a registered read that prefetches the next word on each consumed beat
   always_ff @(posedge clock) begin
      if (wr_en)
         for (int i = 0; i < 4; i++)
            if (byte_en[i]) mem[index][8*i +: 8] <= address_dataIN[8*i +: 8];
      rdata <= mem[rd_index];
   end
   // bus outputs are zero unless the state actively drives them so several slaves can be OR-ed
   always_comb begin
      data_validOUT      = state == READ;
      address_dataOUT    = state == READ ? rdata : 32'd0;
      end_transactionOUT = state == REND;
      busyOUT            = state == WSETUP;
      errorOUT           = (state == ERROR && !absorb) || (state == WRITE && data_validIN && beats_left == 9'd0);
   end
endmodule

// File: tb/tb_jtag_bus_sram_slave.sv
// tb_jtag_bus_sram_slave: randomized scoreboard bench against a word-array model of the SRAM slave
module tb_jtag_bus_sram_slave;
   logic        clock = 1'b0;
   logic        n_reset = 1'b0;
   logic [31:0] address_dataIN = '0;
   logic [3:0]  byte_enableIN = '0;
   logic [7:0]  burst_sizeIN = '0;
   logic        read_n_writeIN = 1'b0;
   logic        begin_transactionIN = 1'b0;
   logic        end_transactionIN = 1'b0;
   logic        data_validIN = 1'b0;
   logic        busyIN = 1'b0;
   logic [31:0] address_dataOUT;
   logic        end_transactionOUT, data_validOUT, busyOUT, errorOUT;
   int          checks = 0;
   int          errors = 0;
   int          err_seen = 0;
   logic [31:0] model [1024];
   logic [31:0] exp_q [$];

   jtag_bus_sram_slave dut (
      .clock(clock), .n_reset(n_reset),
      .address_dataIN(address_dataIN), .byte_enableIN(byte_enableIN),
      .burst_sizeIN(burst_sizeIN), .read_n_writeIN(read_n_writeIN),
      .begin_transactionIN(begin_transactionIN), .end_transactionIN(end_transactionIN),
      .data_validIN(data_validIN), .busyIN(busyIN),
      .address_dataOUT(address_dataOUT), .end_transactionOUT(end_transactionOUT),
      .data_validOUT(data_validOUT), .busyOUT(busyOUT), .errorOUT(errorOUT)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_b(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return a[31:12] == 20'h40000;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   task automatic outputs_zero(input string name);
      chk(name, address_dataOUT, 32'd0);
      chk_b(name, data_validOUT, 1'b0);
      chk_b(name, end_transactionOUT, 1'b0);
      chk_b(name, busyOUT, 1'b0);
      chk_b(name, errorOUT, 1'b0);
   endtask

   // monitor: compares every presented read beat with the scoreboard head, pops on consumption
   always @(negedge clock) begin
      if (n_reset) begin
         if (errorOUT) err_seen++;
         if (data_validOUT) begin
            if (exp_q.size() == 0) chk_b("unexpected_read_beat", data_validOUT, 1'b0);
            else begin
               chk("read_data", address_dataOUT, exp_q[0]);
               if (!busyIN) void'(exp_q.pop_front());
            end
         end else chk("undriven_data_zero", address_dataOUT, 32'd0);
      end
   end

   task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int burst,
                           input int nbeats, input bit end_last, input bit fixed, input logic [31:0] d0);
      bit          sel, ok;
      int          idx, e0, exp_err, gap;
      logic [31:0] d, m;
      sel = in_window(addr);
      ok  = sel && addr[1:0] == 2'b00;
      idx = {22'd0, addr[11:2]};
      m   = lane_mask(be);
      e0  = err_seen;
      exp_err = !sel ? 0 : !ok ? 1 : (nbeats > burst + 1 ? nbeats - burst - 1 : 0);
      @(posedge clock); #1;
      begin_transactionIN = 1'b1;
      address_dataIN = addr;
      byte_enableIN = be;
      burst_sizeIN = 8'(burst);
      read_n_writeIN = 1'b0;
      @(posedge clock); #1;
      begin_transactionIN = 1'b0;
      address_dataIN = $urandom;
      chk_b("wr_busy_t1", busyOUT, ok);
      chk_b("wr_err_t1", errorOUT, sel && !ok);
      for (int k = 0; k < nbeats; k++) begin
         @(posedge clock); #1;
         data_validIN = 1'b0;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clock); #1;
         end
         d = fixed ? d0 * (k + 1) : $urandom;
         address_dataIN = d;
         data_validIN = 1'b1;
         end_transactionIN = end_last && k == nbeats - 1;
         if (ok && k <= burst) model[(idx + k) % 1024] = (model[(idx + k) % 1024] & ~m) | (d & m);
      end
      @(posedge clock); #1;
      data_validIN = 1'b0;
      end_transactionIN = 1'b0;
      if (!end_last) begin
         end_transactionIN = 1'b1;
         @(posedge clock); #1;
         end_transactionIN = 1'b0;
      end
      chk("wr_error_pulses", err_seen - e0, exp_err);
   endtask

   // mode: 0 no stall, 1 random stall, 2 two-cycle stall on beat event_at, 3 abort at beat event_at, 4 reset at beat event_at
   task automatic do_read(input logic [31:0] addr, input int burst, input int mode, input int event_at);
      bit sel, ok, busy;
      int idx, e0, cyc, consumed, stalls, held;
      sel = in_window(addr);
      ok  = sel && addr[1:0] == 2'b00;
      idx = {22'd0, addr[11:2]};
      e0  = err_seen;
      if (ok) for (int k = 0; k <= burst; k++) exp_q.push_back(model[(idx + k) % 1024]);
      @(posedge clock); #1;
      begin_transactionIN = 1'b1;
      address_dataIN = addr;
      byte_enableIN = 4'($urandom);
      burst_sizeIN = 8'(burst);
      read_n_writeIN = 1'b1;
      @(posedge clock); #1;
      begin_transactionIN = 1'b0;
      address_dataIN = $urandom;
      if (!ok) begin
         chk_b("rd_err_t1", errorOUT, sel);
         for (int c = 0; c < 3; c++) begin
            chk_b("rd_no_valid", data_validOUT, 1'b0);
            chk_b("rd_no_end", end_transactionOUT, 1'b0);
            chk_b("rd_no_busy", busyOUT, 1'b0);
            @(posedge clock); #1;
         end
         chk("rd_error_pulses", err_seen - e0, sel ? 1 : 0);
         return;
      end
      cyc = 1; consumed = 0; stalls = 0; held = 0;
      forever begin
         if (end_transactionOUT) begin
            chk("rd_end_cycle", cyc, burst + 3 + stalls);
            chk_b("rend_valid_low", data_validOUT, 1'b0);
            break;
         end
         if (cyc == 2) chk_b("rd_first_valid_t2", data_validOUT, 1'b1);
         if (mode == 3 && consumed == event_at && data_validOUT) begin
            busyIN = 1'b1;
            end_transactionIN = 1'b1;
            @(posedge clock); #1;
            end_transactionIN = 1'b0;
            busyIN = 1'b0;
            outputs_zero("abort_outputs");
            exp_q.delete();
            return;
         end
         if (mode == 4 && consumed == event_at && data_validOUT) begin
            busyIN = 1'b0;
            #2 n_reset = 1'b0;
            #1 outputs_zero("async_reset_outputs");
            exp_q.delete();
            @(posedge clock); #3 n_reset = 1'b1;
            return;
         end
         busy = mode == 1 ? $urandom_range(0, 3) == 0 : mode == 2 ? (consumed == event_at && held < 2) : 1'b0;
         busyIN = busy;
         if (data_validOUT) begin
            if (busy) begin
               stalls++;
               held++;
            end else consumed++;
         end
         if (cyc > burst + 600) begin
            chk("rd_timeout", cyc, burst + 3 + stalls);
            exp_q.delete();
            break;
         end
         @(posedge clock); #1;
         cyc++;
      end
      busyIN = 1'b0;
      chk("rd_beats_consumed", consumed, burst + 1);
      if (mode == 2) chk("rd_stall_cycles", stalls, 2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clock);
      #1 outputs_zero("reset_outputs");
      @(posedge clock); #3 n_reset = 1'b1;
      for (int c = 0; c < 4; c++) do_write(32'h4000_0000 + c * 1024, 4'hF, 255, 256, 1'b1, 1'b0, 32'd0);
      do_write(32'h4000_0010, 4'hF, 3, 4, 1'b1, 1'b1, 32'h11);
      do_read(32'h4000_0010, 3, 0, 0);
      do_write(32'h4000_0000, 4'hF, 0, 1, 1'b1, 1'b1, 32'd0);
      do_write(32'h4000_0000, 4'b0101, 0, 1, 1'b1, 1'b1, 32'hAABB_CCDD);
      chk("model_byte_enable", model[0], 32'h00BB_00DD);
      do_read(32'h4000_0000, 0, 0, 0);
      do_read(32'h4000_0100, 3, 2, 1);
      do_write(32'h4000_0FFC, 4'hF, 1, 3, 1'b1, 1'b0, 32'd0);
      do_read(32'h4000_0FFC, 1, 0, 0);
      do_read(32'h4000_0002, 0, 0, 0);
      do_write(32'h4000_0011, 4'hF, 2, 3, 1'b0, 1'b0, 32'd0);
      do_read(32'h4000_0010, 3, 1, 0);
      do_read(32'h5000_0000, 3, 0, 0);
      do_write(32'h5000_0000, 4'hF, 0, 1, 1'b0, 1'b0, 32'd0);
      do_read(32'h4000_0200, 3, 4, 1);
      do_read(32'h4000_0200, 3, 0, 0);
      do_read(32'h4000_0300, 7, 3, 2);
      do_write(32'h4000_0400, 4'($urandom), 7, 3, 1'b0, 1'b0, 32'd0);
      do_read(32'h4000_0400, 7, 1, 0);
      for (int n = 0; n < 30; n++) begin
         int b;
         logic [31:0] a;
         b = $urandom_range(0, 15);
         a = 32'h4000_0000 + ($urandom_range(0, 1023) << 2);
         if ($urandom_range(0, 1) == 1)
            do_write(a, 4'($urandom), b, $urandom_range(1, b + 3), 1'($urandom), 1'b0, 32'd0);
         else
            do_read(a, b, 1, 0);
      end
      repeat (2) @(posedge clock);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
